// File: rtl/mul_job_arbiter.sv
// Round-robin sequencer sharing one shift-add multiplier core among NREQ requesters; each job is
// grant, clear, load, run (watchdog TIMEOUT), finish and gap; requesters hold req until rsp_valid.
module mul_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_p,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_clrn,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic              mul_load_a,
    output logic              mul_load_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [15:0]       mul_p
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_RUN, S_FIN, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            rst_dly_q, rst_dly_d;
    logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_p_q, rsp_p_d;
    logic            rsp_err_q, rsp_err_d;
    logic            mul_clrn_q, mul_clrn_d, mul_load_q, mul_load_d, mul_start_q, mul_start_d;
    logic [7:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;

    logic [IW-1:0]   pick_idx, cand;
    logic            pick_vld;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requester at or above the round-robin pointer, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rst_dly_d   = 1'b0;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_p_d     = rsp_p_q;
        rsp_err_d   = rsp_err_q;
        mul_clrn_d  = !rst_dly_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_load_d  = 1'b0;
        mul_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_CLR;
                    win_d   = pick_idx;
                    err_d   = 1'b0;
                    gnt_d   = onehot(pick_idx);
                    mul_a_d = req_a[{pick_idx, 3'b000} +: 8];
                    mul_b_d = req_b[{pick_idx, 3'b000} +: 8];
                end
            end
            S_CLR: begin
                mul_clrn_d = 1'b0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                mul_load_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                mul_start_d = 1'b1;
                if (mul_done) begin
                    state_d = S_FIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                rsp_valid_d = onehot(win_q);
                rsp_p_d     = err_q ? 16'd0 : mul_p;
                rsp_err_d   = err_q;
                gnt_d       = '0;
                rr_d        = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d     = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // rst_dly_q keeps the core clear asserted for one cycle beyond reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rst_dly_q   <= 1'b1;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
            mul_clrn_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_load_q  <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rst_dly_q   <= rst_dly_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_err_q   <= rsp_err_d;
            mul_clrn_q  <= mul_clrn_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_load_q  <= mul_load_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_p      = rsp_p_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);
    assign mul_clrn   = mul_clrn_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_load_a = mul_load_q;
    assign mul_load_b = mul_load_q;
    assign mul_start  = mul_start_q;

endmodule

// File: tb/tb_mul_job_arbiter.sv
// Bench for mul_job_arbiter with a behavioural shift-add core whose sum only clears on clrn.
// A job-level model predicts every output each cycle; directed tests pin it with literal results.
module tb_mul_job_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 8;
    localparam int JOB_R   = LAT + 5;

    logic              clk = 1'b0;
    logic              clr;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [15:0]       rsp_p, mul_p;
    logic              rsp_err, busy, mul_clrn, mul_load_a, mul_load_b, mul_start, mul_done;
    logic [7:0]        mul_a, mul_b;
    logic              core_stuck;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err), .busy(busy),
        .mul_clrn(mul_clrn), .mul_a(mul_a), .mul_b(mul_b), .mul_load_a(mul_load_a),
        .mul_load_b(mul_load_b), .mul_start(mul_start), .mul_done(mul_done), .mul_p(mul_p)
    );

    // Core: done rises LAT start-cycles after load; sum accumulates and never self-clears.
    logic [7:0]  c_a = '0, c_b = '0;
    logic [15:0] c_sum = '0;
    logic        c_done = 1'b0;
    int          c_cnt = 0;
    always @(posedge clk) begin
        if (!mul_clrn) begin
            c_a <= '0; c_b <= '0; c_sum <= '0; c_done <= 1'b0; c_cnt <= 0;
        end else begin
            if (mul_load_a) c_a <= mul_a;
            if (mul_load_b) c_b <= mul_b;
            if (mul_start && !c_done && !core_stuck) begin
                if (c_cnt == LAT - 1) begin
                    c_done <= 1'b1;
                    c_sum  <= c_sum + c_a * c_b;
                end else begin
                    c_cnt <= c_cnt + 1;
                end
            end
        end
    end
    assign mul_done = c_done;
    assign mul_p    = c_sum;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    endtask

    function automatic int first_bit(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Job-level model: m_k counts cycles since the grant became visible.
    logic m_valid = 1'b0, m_active = 1'b0, m_stuck = 1'b0, m_found;
    int   m_k, m_w, m_R, m_rr, m_a, m_b, m_rstc, m_rsp_p, m_rsp_err, m_idx;
    logic [NREQ-1:0] prev_gnt = '0;
    int   r_idx[$], r_p[$], r_err[$], r_cyc[$], g_idx[$], g_cyc[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("gnt", int'(gnt), (m_active && m_k < m_R) ? (1 << m_w) : 0);
            chk("rsp_valid", int'(rsp_valid), (m_active && m_k == m_R) ? (1 << m_w) : 0);
            chk("rsp_p", int'(rsp_p), m_rsp_p);
            chk("rsp_err", int'(rsp_err), m_rsp_err);
            chk("busy", int'(busy), m_active ? 1 : 0);
            chk("mul_clrn", int'(mul_clrn), (m_rstc > 0 || (m_active && m_k == 1)) ? 0 : 1);
            chk("mul_load_a", int'(mul_load_a), (m_active && m_k == 2) ? 1 : 0);
            chk("mul_load_b", int'(mul_load_b), (m_active && m_k == 2) ? 1 : 0);
            chk("mul_start", int'(mul_start), (m_active && m_k >= 3 && m_k < m_R) ? 1 : 0);
            chk("mul_a", int'(mul_a), m_a);
            chk("mul_b", int'(mul_b), m_b);
        end
        if (rsp_valid != '0) begin
            r_idx.push_back(first_bit(rsp_valid));
            r_p.push_back(int'(rsp_p));
            r_err.push_back(int'(rsp_err));
            r_cyc.push_back(cyc);
        end
        if (gnt != '0 && prev_gnt == '0) begin
            g_idx.push_back(first_bit(gnt));
            g_cyc.push_back(cyc);
        end
        prev_gnt = gnt;
        if (clr) begin
            m_valid = 1'b1; m_active = 1'b0; m_rr = 0; m_a = 0; m_b = 0;
            m_rsp_p = 0; m_rsp_err = 0; m_rstc = 2;
        end else if (m_valid) begin
            if (m_rstc > 0) m_rstc--;
            if (m_active) begin
                if (m_k == m_R) m_active = 1'b0;
                else begin
                    m_k++;
                    if (m_k == m_R) begin
                        m_rsp_err = m_stuck ? 1 : 0;
                        m_rsp_p   = m_stuck ? 0 : m_a * m_b;
                        m_rr      = (m_w + 1) % NREQ;
                    end
                end
            end else if (req != '0) begin
                m_found = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    m_idx = (m_rr + i) % NREQ;
                    if (!m_found && req[m_idx]) begin
                        m_found = 1'b1;
                        m_w     = m_idx;
                    end
                end
                m_active = 1'b1;
                m_k      = 0;
                m_a      = int'(req_a[8*m_w +: 8]);
                m_b      = int'(req_b[8*m_w +: 8]);
                m_stuck  = core_stuck;
                m_R      = core_stuck ? TIMEOUT + 3 : JOB_R;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (r_idx.size() < n && t < budget) begin tick(1); t++; end
        chk({name, "_rsp_arrived"}, (r_idx.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_gnt(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (g_idx.size() < n && t < budget) begin tick(1); t++; end
        chk({name, "_gnt_arrived"}, (g_idx.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic check_rsp(input int i, input string name, input int e_idx, input int e_p, input int e_err);
        if (i < r_idx.size()) begin
            chk({name, "_idx"}, r_idx[i], e_idx);
            chk({name, "_p"}, r_p[i], e_p);
            chk({name, "_err"}, r_err[i], e_err);
        end else begin
            chk({name, "_missing"}, r_idx.size(), i + 1);
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int rb, gb;
        clr = 1'b1; req = '0; req_a = '0; req_b = '0; core_stuck = 1'b0;
        tick(2);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clrn", int'(mul_clrn), 0);
        chk("rst_rsp_p", int'(rsp_p), 0);
        clr = 1'b0;
        tick(1);
        chk("rst_clrn_hold", int'(mul_clrn), 0);
        tick(1);
        chk("rst_clrn_release", int'(mul_clrn), 1);

        // Single job 12*11.
        set_op(0, 12, 11);
        req = 4'b0001;
        wait_rsp(1, TIMEOUT + 5, "t1");
        req = '0;
        check_rsp(0, "t1", 0, 132, 0);
        if (g_cyc.size() > 0 && r_cyc.size() > 0) chk("t1_latency", r_cyc[0] - g_cyc[0], 13);
        tick(2);

        // All four held: served 0,1,2,3 then wrap to 0.
        do_reset();
        set_op(0, 255, 255); set_op(1, 0, 77); set_op(2, 3, 0); set_op(3, 200, 100);
        rb = r_idx.size(); gb = g_idx.size();
        req = 4'b1111;
        wait_rsp(rb + 5, 5 * (JOB_R + 2) + 10, "t2");
        req = '0;
        check_rsp(rb + 0, "t2_j0", 0, 65025, 0);
        check_rsp(rb + 1, "t2_j1", 1, 0, 0);
        check_rsp(rb + 2, "t2_j2", 2, 0, 0);
        check_rsp(rb + 3, "t2_j3", 3, 20000, 0);
        check_rsp(rb + 4, "t2_wrap", 0, 65025, 0);
        if (g_cyc.size() > gb + 1) chk("t2_spacing", g_cyc[gb + 1] - g_cyc[gb], 15);
        tick(2);

        // req0 held, req2 arrives mid-job: req2 gets the next slot.
        set_op(0, 5, 6); set_op(2, 7, 9);
        rb = r_idx.size(); gb = g_idx.size();
        req = 4'b0001;
        wait_gnt(gb + 1, 10, "t3a");
        req = 4'b0101;
        wait_gnt(gb + 2, 2 * (JOB_R + 2) + 5, "t3b");
        if (g_idx.size() > gb + 1) chk("t3_next_gnt", g_idx[gb + 1], 2);
        wait_rsp(rb + 2, 3 * (JOB_R + 2) + 10, "t3");
        req = '0;
        check_rsp(rb + 0, "t3_j0", 0, 30, 0);
        check_rsp(rb + 1, "t3_j2", 2, 63, 0);
        tick(2);

        // Core never finishes: watchdog abort, then a normal job.
        core_stuck = 1'b1;
        set_op(1, 3, 4);
        rb = r_idx.size(); gb = g_idx.size();
        req = 4'b0010;
        wait_rsp(rb + 1, TIMEOUT + 10, "t4");
        req = '0;
        core_stuck = 1'b0;
        check_rsp(rb, "t4_abort", 1, 0, 1);
        if (g_cyc.size() > gb && r_cyc.size() > rb) chk("t4_latency", r_cyc[rb] - g_cyc[gb], TIMEOUT + 3);
        tick(1);
        req = 4'b0010;
        wait_rsp(rb + 2, TIMEOUT + 5, "t4b");
        req = '0;
        check_rsp(rb + 1, "t4_retry", 1, 12, 0);
        tick(2);

        // Reset during RUN aborts silently; the held request then completes correctly.
        set_op(0, 12, 11);
        rb = r_idx.size();
        req = 4'b0001;
        for (int t = 0; t < 10 && !mul_start; t++) tick(1);
        chk("t5_in_run", int'(mul_start), 1);
        tick(2);
        clr = 1'b1;
        tick(1);
        chk("t5_gnt", int'(gnt), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_start", int'(mul_start), 0);
        chk("t5_clrn", int'(mul_clrn), 0);
        chk("t5_mul_a", int'(mul_a), 0);
        chk("t5_rsp_p", int'(rsp_p), 0);
        chk("t5_no_rsp", r_idx.size(), rb);
        clr = 1'b0;
        wait_rsp(rb + 1, TIMEOUT + 8, "t5");
        req = '0;
        check_rsp(rb, "t5_fresh", 0, 132, 0);
        tick(2);

        // Operand change and req drop after grant: result uses frozen operands.
        set_op(0, 12, 11);
        rb = r_idx.size(); gb = g_idx.size();
        req = 4'b0001;
        wait_gnt(gb + 1, 5, "t6");
        set_op(0, 99, 11);
        req = '0;
        wait_rsp(rb + 1, TIMEOUT + 5, "t6");
        check_rsp(rb, "t6_frozen", 0, 132, 0);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
